// File: rtl/vga_pkg.sv
// Shared constants for the VGA pixel fetch pipeline: tile geometry, memory-select bit
// positions and default parameter values.
package vga_pkg;
    localparam int TILE_SHIFT = 3;
    localparam int MEM_MAP    = 0;
    localparam int MEM_CHAR   = 1;

    localparam int DEF_NUM_SPRITES = 5;
    localparam int DEF_MAP_ROWS    = 36;
    localparam int DEF_MAP_COLS    = 28;
    localparam int DEF_SPRITE_DIM  = 16;
    localparam int DEF_BLINK_BIT   = 4;
endpackage

// File: rtl/vga_pixel_fetch_pipe_sprite_hit.sv
// One pixel-vs-sprite comparison: reports a hit and the pixel offset inside the sprite.
module sprite_hit
    import vga_pkg::*;
#(
    parameter int SPRITE_DIM = DEF_SPRITE_DIM,
    parameter int OFF_W      = 2 * $clog2(DEF_SPRITE_DIM)
) (
    input  logic             en,
    input  logic             blank,
    input  logic [9:0]       x,
    input  logic [9:0]       y,
    input  logic [9:0]       sx,
    input  logic [9:0]       sy,
    output logic             hit,
    output logic [OFF_W-1:0] offset
);
    localparam int SW = OFF_W / 2;
    localparam logic [9:0] DIM = 10'(SPRITE_DIM);

    logic [9:0] dx;
    logic [9:0] dy;

    assign dx = x - sx;
    assign dy = y - sy;

    // The x >= sx / y >= sy terms stop a coordinate left of or above the sprite from wrapping into range.
    assign hit    = en && !blank && (x >= sx) && (y >= sy) && (dx < DIM) && (dy < DIM);
    assign offset = {dx[SW-1:0], dy[SW-1:0]};
endmodule

// File: rtl/vga_pixel_fetch_pipe.sv
// Two-stage pixel fetch: tile RAM addressing, sprite priority hit and output formatting.
// Optional sprite blinking is enabled by defining VGA_FETCH_BLINK_EN.
module vga_pixel_fetch_pipe
    import vga_pkg::*;
#(
    parameter int NUM_SPRITES = DEF_NUM_SPRITES,
    parameter int MAP_ROWS    = DEF_MAP_ROWS,
    parameter int MAP_COLS    = DEF_MAP_COLS,
    parameter int SPRITE_DIM  = DEF_SPRITE_DIM,
    parameter int BLINK_BIT   = DEF_BLINK_BIT,
    localparam int AW = $clog2(MAP_ROWS * MAP_COLS),
    localparam int WW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
    localparam int OW = 2 * $clog2(SPRITE_DIM)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_valid,
    input  logic [9:0]              i_x_cord,
    input  logic [9:0]              i_y_cord,
    input  logic                    i_frame_start,
    input  logic [NUM_SPRITES-1:0]  i_sprite_en,
    input  logic [NUM_SPRITES*10-1:0] i_sprite_x,
    input  logic [NUM_SPRITES*10-1:0] i_sprite_y,
    input  logic [NUM_SPRITES-1:0]  i_sprite_blink,
    output logic [AW-1:0]           o_map_raddr,
    output logic [AW-1:0]           o_item_raddr,
    input  logic [7:0]              i_map_rdata,
    input  logic [1:0]              i_item_rdata,
    output logic                    o_valid,
    output logic [1:0]              o_mem_select,
    output logic [7:0]              o_address_map,
    output logic [1:0]              o_address_item,
    output logic [WW-1:0]           o_which_char,
    output logic [5:0]              o_tile_offset,
    output logic [OW-1:0]           o_char_offset
);
    localparam logic [10:0] X_LIM = 11'(MAP_ROWS * 8);
    localparam logic [10:0] Y_LIM = 11'(MAP_COLS * 8);

    logic                   active;
    logic [AW-1:0]          raddr;
    logic [NUM_SPRITES-1:0] blank;
    logic [NUM_SPRITES-1:0] hit;
    logic [OW-1:0]          offs [NUM_SPRITES];
    logic                   any_hit;
    logic [WW-1:0]          sel_idx;
    logic [OW-1:0]          sel_off;

    logic                   vld_p1;
    logic                   act_p1;
    logic                   hit_p1;
    logic [5:0]             toff_p1;
    logic [WW-1:0]          idx_p1;
    logic [OW-1:0]          coff_p1;

    assign active = ({1'b0, i_x_cord} < X_LIM) && ({1'b0, i_y_cord} < Y_LIM);
    assign raddr  = active ? AW'(i_x_cord[9:TILE_SHIFT]) * AW'(MAP_COLS) + AW'(i_y_cord[9:TILE_SHIFT])
                           : '0;
    assign o_map_raddr  = raddr;
    assign o_item_raddr = raddr;

`ifdef VGA_FETCH_BLINK_EN
    logic [BLINK_BIT:0] frame_cnt;

    // Pixels arriving alongside the frame pulse still see the old count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            frame_cnt <= '0;
        end else if (i_frame_start) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    assign blank = i_sprite_blink & {NUM_SPRITES{frame_cnt[BLINK_BIT]}};
`else
    logic unused_blink;

    assign blank        = '0;
    assign unused_blink = ^{i_frame_start, i_sprite_blink};
`endif

    for (genvar k = 0; k < NUM_SPRITES; k++) begin : g_hit
        sprite_hit #(
            .SPRITE_DIM (SPRITE_DIM),
            .OFF_W      (OW)
        ) u_hit (
            .en     (i_sprite_en[k]),
            .blank  (blank[k]),
            .x      (i_x_cord),
            .y      (i_y_cord),
            .sx     (i_sprite_x[k*10 +: 10]),
            .sy     (i_sprite_y[k*10 +: 10]),
            .hit    (hit[k]),
            .offset (offs[k])
        );
    end

    // Scan downwards so the lowest-index hitting sprite is the last one written.
    always_comb begin
        any_hit = 1'b0;
        sel_idx = '0;
        sel_off = '0;
        for (int k = NUM_SPRITES - 1; k >= 0; k--) begin
            if (hit[k]) begin
                any_hit = 1'b1;
                sel_idx = WW'(k);
                sel_off = offs[k];
            end
        end
    end

    // Stage 1: coordinate-derived information, RAM read in flight
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_p1  <= 1'b0;
            act_p1  <= 1'b0;
            hit_p1  <= 1'b0;
            toff_p1 <= '0;
            idx_p1  <= '0;
            coff_p1 <= '0;
        end else begin
            vld_p1  <= i_valid;
            act_p1  <= i_valid && active;
            hit_p1  <= i_valid && active && any_hit;
            toff_p1 <= (i_valid && active) ? {i_x_cord[2:0], i_y_cord[2:0]} : 6'd0;
            idx_p1  <= (i_valid && active && any_hit) ? sel_idx : '0;
            coff_p1 <= (i_valid && active && any_hit) ? sel_off : '0;
        end
    end

    // Stage 2: merge RAM data and drive registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid        <= 1'b0;
            o_mem_select   <= '0;
            o_address_map  <= '0;
            o_address_item <= '0;
            o_which_char   <= '0;
            o_tile_offset  <= '0;
            o_char_offset  <= '0;
        end else begin
            o_valid                <= vld_p1;
            o_mem_select[MEM_CHAR] <= hit_p1;
            o_mem_select[MEM_MAP]  <= act_p1;
            o_address_map          <= act_p1 ? i_map_rdata : 8'd0;
            o_address_item         <= act_p1 ? i_item_rdata : 2'd0;
            o_which_char           <= idx_p1;
            o_tile_offset          <= toff_p1;
            o_char_offset          <= coff_p1;
        end
    end
endmodule

// File: tb/tb_vga_pixel_fetch_pipe.sv
// Directed bench for vga_pixel_fetch_pipe with a registered tile RAM model.
module tb_vga_pixel_fetch_pipe;
    logic        clk;
    logic        rst;
    logic        valid;
    logic [9:0]  x_cord;
    logic [9:0]  y_cord;
    logic        frame_start;
    logic [4:0]  sprite_en;
    logic [49:0] sprite_x;
    logic [49:0] sprite_y;
    logic [4:0]  sprite_blink;
    logic [9:0]  map_raddr;
    logic [9:0]  item_raddr;
    logic [7:0]  map_rdata;
    logic [1:0]  item_rdata;
    logic        o_valid;
    logic [1:0]  mem_select;
    logic [7:0]  address_map;
    logic [1:0]  address_item;
    logic [2:0]  which_char;
    logic [5:0]  tile_offset;
    logic [7:0]  char_offset;
    logic [29:0] outs;

    int n_vec;
    int n_bad;

    vga_pixel_fetch_pipe dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_valid        (valid),
        .i_x_cord       (x_cord),
        .i_y_cord       (y_cord),
        .i_frame_start  (frame_start),
        .i_sprite_en    (sprite_en),
        .i_sprite_x     (sprite_x),
        .i_sprite_y     (sprite_y),
        .i_sprite_blink (sprite_blink),
        .o_map_raddr    (map_raddr),
        .o_item_raddr   (item_raddr),
        .i_map_rdata    (map_rdata),
        .i_item_rdata   (item_rdata),
        .o_valid        (o_valid),
        .o_mem_select   (mem_select),
        .o_address_map  (address_map),
        .o_address_item (address_item),
        .o_which_char   (which_char),
        .o_tile_offset  (tile_offset),
        .o_char_offset  (char_offset)
    );

    assign outs = {o_valid, mem_select, address_map, address_item, which_char, tile_offset, char_offset};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] map_word(input logic [9:0] a);
        logic [15:0] p;
        p = 16'(a) * 16'd7 + 16'd3;
        return (a == 10'd0) ? 8'h21 : p[7:0];
    endfunction

    always @(posedge clk) begin
        map_rdata  <= map_word(map_raddr);
        item_rdata <= item_raddr[1:0] ^ 2'b01;
    end

    function automatic logic [29:0] mk(input logic v, input logic [1:0] ms, input logic [7:0] am,
                                       input logic [1:0] ai, input logic [2:0] wc,
                                       input logic [5:0] to, input logic [7:0] co);
        return {v, ms, am, ai, wc, to, co};
    endfunction

    typedef struct {
        logic        vin;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [4:0]  en;
        logic [9:0]  raddr;
        logic [29:0] exp;
    } vec_t;

    function automatic vec_t v(input logic vin, input logic [9:0] x, input logic [9:0] y,
                               input logic [4:0] en, input logic [9:0] ra, input logic [29:0] ex);
        vec_t r;
        r.vin = vin; r.x = x; r.y = y; r.en = en; r.raddr = ra; r.exp = ex;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_pix(input logic [9:0] x, input logic [9:0] y, input logic fs,
                           output logic [29:0] o);
        @(negedge clk);
        x_cord = x; y_cord = y; valid = 1'b1; frame_start = fs;
        @(negedge clk);
        valid = 1'b0; frame_start = 1'b0;
        @(negedge clk);
        #1;
        o = outs;
    endtask

    task automatic pulses(input int n);
        repeat (n) begin
            @(negedge clk); frame_start = 1'b1;
            @(negedge clk); frame_start = 1'b0;
        end
    endtask

    localparam int N = 15;
    vec_t vecs [N];

    initial begin
        logic [29:0] o;
        logic [29:0] vis;
        logic [29:0] hid;

        n_vec = 0;
        n_bad = 0;
        // sprite 0 at (0,0), 1 and 3 at (100,50), 2 at (200,100), 4 at (250,200)
        sprite_x     = {10'd250, 10'd100, 10'd200, 10'd100, 10'd0};
        sprite_y     = {10'd200, 10'd50, 10'd100, 10'd50, 10'd0};
        sprite_en    = '0;
        sprite_blink = '0;
        frame_start  = 1'b0;
        x_cord       = '0;
        y_cord       = '0;
        valid        = 1'b1;
        rst          = 1'b1;

        vecs[0]  = v(1, 0,   0,   5'b00000, 0,    mk(1, 2'b01, 8'h21, 1, 0, 0,  0));
        vecs[1]  = v(1, 105, 52,  5'b01010, 370,  mk(1, 2'b11, 8'h21, 3, 1, 12, 82));
        vecs[2]  = v(1, 300, 10,  5'b11111, 0,    mk(1, 2'b00, 8'h00, 0, 0, 0,  0));
        vecs[3]  = v(1, 3,   3,   5'b00000, 0,    mk(1, 2'b01, 8'h21, 1, 0, 27, 0));
        vecs[4]  = v(1, 3,   3,   5'b00001, 0,    mk(1, 2'b11, 8'h21, 1, 0, 27, 51));
        vecs[5]  = v(1, 115, 65,  5'b01010, 400,  mk(1, 2'b11, 8'hF3, 1, 1, 25, 255));
        vecs[6]  = v(0, 105, 52,  5'b01010, 370,  mk(0, 2'b00, 8'h00, 0, 0, 0,  0));
        vecs[7]  = v(1, 116, 65,  5'b01010, 400,  mk(1, 2'b01, 8'hF3, 1, 0, 33, 0));
        vecs[8]  = v(1, 99,  50,  5'b01010, 342,  mk(1, 2'b01, 8'h5D, 3, 0, 26, 0));
        vecs[9]  = v(1, 205, 110, 5'b11100, 713,  mk(1, 2'b11, 8'h82, 0, 2, 46, 90));
        vecs[10] = v(1, 255, 205, 5'b11000, 893,  mk(1, 2'b11, 8'h6E, 0, 4, 61, 85));
        vecs[11] = v(1, 287, 223, 5'b00000, 1007, mk(1, 2'b01, 8'h8C, 2, 0, 63, 0));
        vecs[12] = v(1, 288, 0,   5'b11111, 0,    mk(1, 2'b00, 8'h00, 0, 0, 0,  0));
        vecs[13] = v(1, 0,   224, 5'b11111, 0,    mk(1, 2'b00, 8'h00, 0, 0, 0,  0));
        vecs[14] = v(1, 250, 200, 5'b10000, 893,  mk(1, 2'b11, 8'h6E, 0, 4, 16, 0));

        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", 32'(outs), 32'd0);
        rst   = 1'b0;
        valid = 1'b0;
        @(negedge clk);
        #1;
        chk("post_reset_idle", 32'(outs), 32'd0);

        // Back-to-back stream: check the address now and the outputs of the vector two cycles back.
        for (int i = 0; i < N + 2; i++) begin
            @(negedge clk);
            if (i < N) begin
                valid = vecs[i].vin; x_cord = vecs[i].x; y_cord = vecs[i].y; sprite_en = vecs[i].en;
            end else begin
                valid = 1'b0; x_cord = '0; y_cord = '0; sprite_en = '0;
            end
            #1;
            if (i < N) begin
                chk($sformatf("map_raddr[%0d]", i), 32'(map_raddr), 32'(vecs[i].raddr));
                chk($sformatf("item_raddr[%0d]", i), 32'(item_raddr), 32'(vecs[i].raddr));
            end
            if (i >= 2) chk($sformatf("outputs[%0d]", i - 2), 32'(outs), 32'(vecs[i - 2].exp));
        end

        // Reset with two pixels in flight.
        @(negedge clk);
        valid = 1'b1; x_cord = 10'd105; y_cord = 10'd52; sprite_en = 5'b01010;
        @(negedge clk);
        x_cord = 10'd0; y_cord = 10'd0;
        @(negedge clk);
        valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_flush", 32'(outs), 32'd0);
        rst = 1'b0; valid = 1'b1; x_cord = 10'd0; y_cord = 10'd0; sprite_en = 5'b00000;
        @(negedge clk);
        #1;
        chk("rst_first_gap", 32'(outs), 32'd0);
        valid = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_first_pixel", 32'(outs), 32'(vecs[0].exp));

        // Blink on sprite 2 across the frame counter.
        sprite_en    = 5'b00100;
        sprite_blink = 5'b00100;
        vis = mk(1, 2'b11, 8'h82, 0, 2, 46, 90);
`ifdef VGA_FETCH_BLINK_EN
        hid = mk(1, 2'b01, 8'h82, 0, 0, 46, 0);
`else
        hid = vis;
`endif
        pulses(15);
        run_pix(205, 110, 1'b1, o);
        chk("blink_same_cycle_pulse", 32'(o), 32'(vis));
        run_pix(205, 110, 1'b0, o);
        chk("blink_frame16", 32'(o), 32'(hid));
        pulses(15);
        run_pix(205, 110, 1'b0, o);
        chk("blink_frame31", 32'(o), 32'(hid));
        pulses(1);
        run_pix(205, 110, 1'b0, o);
        chk("blink_wrapped", 32'(o), 32'(vis));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
